// File: rtl/spi_pkg.sv
// spi_pkg: register map, status bit positions and SPI mode helpers shared by the SPI master and slave
package spi_pkg;
  typedef enum logic [2:0] {
    ADR_RXD  = 3'd0,
    ADR_TXD  = 3'd1,
    ADR_STAT = 3'd2,
    ADR_CTRL = 3'd3
  } reg_adr_e;

  localparam int ST_TXE = 0;
  localparam int ST_RXF = 1;
  localparam int ST_OVR = 2;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // A mode parameter of 0..3 is hard-wired; anything else defers to the control register.
  function automatic spi_mode_t mode_sel(int mode, logic cpolr, logic cphar);
    spi_mode_t m;
    if (mode >= 0 && mode <= 3) begin
      m.cpol = mode[1];
      m.cpha = mode[0];
    end else begin
      m.cpol = cpolr;
      m.cpha = cphar;
    end
    return m;
  endfunction

  // Byte presented on MISO at the start of a transfer: pending TX data or all ones.
  function automatic logic [7:0] tx_reload(logic txv, logic [7:0] txb);
    return txv ? txb : IDLE_BYTE;
  endfunction
endpackage

// File: rtl/spi_slave_top_if.sv
// spi_slave_top_if: zero-wait Wishbone register bus between CPU and the SPI slave
interface spi_slave_top_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [2:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;

  modport master (output stb, cyc, we, adr, wdat, input rdat, ack);
  modport slave (input stb, cyc, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an SPI pin followed by a rise/fall detector
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  // shift the pin through the synchroniser and keep one extra flop for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_top.sv
// spi_slave_top: Wishbone-attached SPI target with one-deep RX/TX buffers and a level interrupt
module spi_slave_top
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_slave_top_if.slave   bus,
  output logic             int_o,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE
);
  logic       sclk_q, sclk_rise, sclk_fall;
  logic       ss_q, ss_rise, ss_fall;
  logic       mosi_q;
  logic       unused_sclk_q, unused_mosi_rise, unused_mosi_fall;
  logic       unused_wdat;
  logic [7:0] rxd, txb, tx_sr;
  logic [6:0] rx_sr;
  logic [2:0] cnt;
  logic [2:0] stat;
  logic       rxf, txv, ovr, rxien, txien, cpolr, cphar, skip;
  logic       leading, trailing, sample, shift, rd, wr;
  spi_mode_t  mode_l, mode_now;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
    .clk_i(clk_i), .rst_i(rst_i), .d(SS_N), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d(MOSI), .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  assign unused_sclk_q = sclk_q;
  assign unused_wdat   = ^bus.wdat[31:8];
  assign mode_now = mode_sel(SPI_MODE, cpolr, cphar);
  assign leading  = mode_l.cpol ? sclk_fall : sclk_rise;
  assign trailing = mode_l.cpol ? sclk_rise : sclk_fall;
  assign sample   = mode_l.cpha ? trailing : leading;
  assign shift    = mode_l.cpha ? leading : trailing;
  assign rd       = bus.stb & bus.cyc & ~bus.we;
  assign wr       = bus.stb & bus.cyc & bus.we;

  // assemble status from the named bit positions
  always_comb begin
    stat = '0;
    stat[ST_TXE] = ~txv;
    stat[ST_RXF] = rxf;
    stat[ST_OVR] = ovr;
  end

  // zero-wait read mux; unmapped addresses read as zero
  always_comb begin
    bus.rdat = bus.adr == ADR_RXD  ? {24'd0, rxd} :
               bus.adr == ADR_TXD  ? {24'd0, txb} :
               bus.adr == ADR_STAT ? {29'd0, stat} :
               bus.adr == ADR_CTRL ? {30'd0, cpolr, cphar} : 32'd0;
  end

  assign bus.ack = bus.stb & bus.cyc;
  assign int_o   = (rxf & rxien) | (~txv & txien);
  assign MISO    = tx_sr[7];
  assign MISO_OE = ~ss_q;

  // SPI framing, shifting and register writes; later statements win on same-cycle conflicts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd    <= '0;
      txb    <= '0;
      rxf    <= 1'b0;
      txv    <= 1'b0;
      ovr    <= 1'b0;
      rxien  <= 1'b0;
      txien  <= 1'b0;
      cpolr  <= 1'b0;
      cphar  <= 1'b0;
      tx_sr  <= IDLE_BYTE;
      rx_sr  <= '0;
      cnt    <= '0;
      skip   <= 1'b0;
      mode_l <= '0;
    end else begin
      if (rd && bus.adr == ADR_RXD) rxf <= 1'b0;
      if (ss_fall) begin
        mode_l <= mode_now;
        tx_sr  <= tx_reload(txv, txb);
        txv    <= 1'b0;
        cnt    <= '0;
        skip   <= mode_now.cpha;
      end else if (ss_rise) begin
        cnt <= '0;
      end else if (!ss_q) begin
        if (sample) begin
          rx_sr <= {rx_sr[5:0], mosi_q};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            rxd   <= {rx_sr, mosi_q};
            rxf   <= 1'b1;
            ovr   <= ovr | rxf;
            tx_sr <= tx_reload(txv, txb);
            txv   <= 1'b0;
            skip  <= 1'b1;
          end
        end
        if (shift) begin
          if (skip) skip <= 1'b0;
          else tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
      if (wr && bus.adr == ADR_TXD) begin
        txb <= bus.wdat[7:0];
        txv <= 1'b1;
      end
      if (wr && bus.adr == ADR_STAT) begin
        if (bus.wdat[2]) ovr <= 1'b0;
        rxien <= bus.wdat[1];
        txien <= bus.wdat[0];
      end
      if (wr && bus.adr == ADR_CTRL) begin
        cpolr <= bus.wdat[1];
        cphar <= bus.wdat[0];
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_top.sv
// tb_spi_slave_top: directed checks of the SPI slave register map, framing, modes and reset
module tb_spi_slave_top;
  localparam int H = 80;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic int_o, sclk, ss_n, mosi, miso, miso_oe;
  logic [31:0] rv;
  logic [7:0] mb;
  int checks = 0;
  int errors = 0;

  spi_slave_top_if bus ();

  spi_slave_top #(.SPI_MODE(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .int_o(int_o),
    .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi), .MISO(miso), .MISO_OE(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.stb = 1'b1; bus.cyc = 1'b1; bus.we = 1'b1; bus.adr = a; bus.wdat = d;
    @(posedge clk); #1;
    bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.stb = 1'b1; bus.cyc = 1'b1; bus.we = 1'b0; bus.adr = a;
    #1;
    d = bus.rdat;
    chk("ack", {31'd0, bus.ack}, 32'd1);
    @(posedge clk); #1;
    bus.stb = 1'b0; bus.cyc = 1'b0;
  endtask

  task automatic spi_sel(input logic cp);
    sclk = cp; #H;
    ss_n = 1'b0; #H;
  endtask

  task automatic spi_desel();
    #H; ss_n = 1'b1; #(2*H);
  endtask

  task automatic spi_bits(input logic cp, input logic ph, input logic [7:0] d, input int n, output logic [7:0] m);
    m = '0;
    for (int i = 7; i > 7 - n; i--) begin
      if (!ph) begin
        mosi = d[i]; #H;
        sclk = ~cp; m = {m[6:0], miso}; #H;
        sclk = cp;
      end else begin
        sclk = ~cp; mosi = d[i]; #H;
        sclk = cp; m = {m[6:0], miso}; #H;
      end
    end
  endtask

  task automatic xfer0(input logic [7:0] d, output logic [7:0] m);
    spi_sel(1'b0);
    spi_bits(1'b0, 1'b0, d, 8, m);
    spi_desel();
  endtask

  initial begin
    bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wdat = '0;
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    #23; rst = 1'b0;
    chk("rst_miso", {31'd0, miso}, 32'd1);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_int", {31'd0, int_o}, 32'd0);
    wb_read(3'd2, rv); chk("rst_stat", rv, 32'h1);
    wb_read(3'd0, rv); chk("rst_rxd", rv, 32'h0);
    wb_read(3'd5, rv); chk("unmapped", rv, 32'h0);
    // mode 0, TX A5, RX 3C
    wb_write(3'd2, 32'h2);
    wb_write(3'd3, 32'h0);
    wb_write(3'd1, 32'hA5);
    wb_read(3'd1, rv); chk("txb_rd", rv, 32'hA5);
    wb_read(3'd2, rv); chk("stat_txfull", rv, 32'h0);
    spi_sel(1'b0);
    chk("sel_oe", {31'd0, miso_oe}, 32'd1);
    spi_bits(1'b0, 1'b0, 8'h3C, 8, mb);
    spi_desel();
    chk("m0_miso", {24'd0, mb}, 32'hA5);
    chk("m0_int", {31'd0, int_o}, 32'd1);
    wb_read(3'd2, rv); chk("m0_stat", rv, 32'h3);
    wb_read(3'd0, rv); chk("m0_rxd", rv, 32'h3C);
    wb_read(3'd2, rv); chk("m0_stat_clr", rv, 32'h1);
    chk("m0_int_clr", {31'd0, int_o}, 32'd0);
    // mode 3, back-to-back bytes with TX refilled inside the frame
    wb_write(3'd3, 32'h3);
    wb_read(3'd3, rv); chk("ctrl_rd", rv, 32'h3);
    wb_write(3'd1, 32'h5A);
    spi_sel(1'b1);
    wb_write(3'd1, 32'h96);
    spi_bits(1'b1, 1'b1, 8'h12, 8, mb);
    chk("m3_miso1", {24'd0, mb}, 32'h5A);
    wb_read(3'd0, rv); chk("m3_rxd1", rv, 32'h12);
    spi_bits(1'b1, 1'b1, 8'h34, 8, mb);
    chk("m3_miso2", {24'd0, mb}, 32'h96);
    spi_desel();
    wb_read(3'd0, rv); chk("m3_rxd2", rv, 32'h34);
    wb_read(3'd2, rv); chk("m3_stat", rv, 32'h1);
    // no TX write: idle ones on MISO
    wb_write(3'd3, 32'h0);
    sclk = 1'b0; #H;
    xfer0(8'h81, mb);
    chk("idle_miso", {24'd0, mb}, 32'hFF);
    wb_read(3'd2, rv); chk("idle_stat", rv, 32'h3);
    wb_read(3'd0, rv); chk("idle_rxd", rv, 32'h81);
    // overrun and its clear
    xfer0(8'h11, mb);
    xfer0(8'h22, mb);
    wb_read(3'd2, rv); chk("ovr_stat", rv, 32'h7);
    wb_read(3'd0, rv); chk("ovr_rxd", rv, 32'h22);
    wb_write(3'd2, 32'h4);
    wb_read(3'd2, rv); chk("ovr_clr", rv, 32'h1);
    // TX-empty interrupt
    wb_write(3'd2, 32'h1);
    chk("txe_int", {31'd0, int_o}, 32'd1);
    wb_write(3'd2, 32'h0);
    chk("txe_int_off", {31'd0, int_o}, 32'd0);
    // aborted partial byte then a full one
    spi_sel(1'b0);
    spi_bits(1'b0, 1'b0, 8'hFF, 5, mb);
    spi_desel();
    wb_read(3'd2, rv); chk("part_stat", rv, 32'h1);
    xfer0(8'hC3, mb);
    wb_read(3'd2, rv); chk("full_stat", rv, 32'h3);
    wb_read(3'd0, rv); chk("full_rxd", rv, 32'hC3);
    // asynchronous reset in the middle of a byte
    xfer0(8'h55, mb);
    wb_write(3'd1, 32'h00);
    wb_write(3'd2, 32'h2);
    chk("pre_rst_int", {31'd0, int_o}, 32'd1);
    spi_sel(1'b0);
    spi_bits(1'b0, 1'b0, 8'hF0, 4, mb);
    chk("pre_rst_miso", {31'd0, miso}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("arst_miso", {31'd0, miso}, 32'd1);
    chk("arst_oe", {31'd0, miso_oe}, 32'd0);
    chk("arst_int", {31'd0, int_o}, 32'd0);
    ss_n = 1'b1; sclk = 1'b0; #40;
    @(negedge clk); rst = 1'b0;
    wb_read(3'd2, rv); chk("arst_stat", rv, 32'h1);
    wb_read(3'd0, rv); chk("arst_rxd", rv, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
